// File: rtl/fifo_umbrales.sv
// Single-clock FIFO with programmable almost-full / almost-empty thresholds.
// One instance per traffic queue, feeding the transaction-layer control FSM.
module fifo_umbrales #(
  parameter int unsigned WORD_SIZE = 12,
  parameter int unsigned MEM_SIZE  = 8,
  parameter int unsigned PTR       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_rd,
  input  logic [PTR-1:0]       full_threshold,
  input  logic [PTR-1:0]       empty_threshold,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error,
  output logic [PTR:0]         count
);

  localparam logic [PTR:0] DepthCnt = (PTR + 1)'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];

  logic [PTR-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR:0]         count_q, count_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;

  logic is_empty, is_full;
  logic rd_acc, wr_acc;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthCnt);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside an accepted read. There is no bypass when empty.
  assign rd_acc = fifo_rd && !is_empty;
  assign wr_acc = fifo_wr && (!is_full || rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR'(1);
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR'(1);
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (PTR + 1)'(1);
      2'b01:   count_d = count_q - (PTR + 1)'(1);
      default: count_d = count_q;
    endcase

    // Sticky: dropped write (overflow) or read on empty (underflow).
    if ((fifo_wr && !wr_acc) || (fifo_rd && is_empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is not reset; its contents are unobservable while count is zero.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem_q[wr_ptr_q] <= fifo_data_in;
    end
  end

  assign fifo_data_out = data_out_q;
  assign fifo_valid    = valid_q;
  assign fifo_error    = error_q;
  assign count         = count_q;
  assign fifo_empty    = is_empty;
  assign fifo_full     = is_full;
  assign almost_full   = (full_threshold != '0) && (count_q >= {1'b0, full_threshold});
  assign almost_empty  = (count_q <= {1'b0, empty_threshold});

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds, one instance per traffic queue. It sits directly upstream of the transaction-layer control state machine. Its `fifo_empty` output is one bit of the 9-bit `fifos_empty` bus that the state machine monitors. It consumes the state machine's registered `fifos_full_threshold` / `fifos_empty_threshold` outputs as its threshold inputs.

## Interface
- `WORD_SIZE`, 12, word width: [11:10] class, [9:8] destination, [7:0] data.
- `MEM_SIZE`, 8, depth in words; must equal 2**PTR.
- `PTR`, 3, pointer width, log2(MEM_SIZE).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `fifo_wr`  in  1  write request.
- `fifo_data_in`  in  WORD_SIZE  write data.
- `fifo_rd`  in  1  read request.
- `full_threshold`  in  PTR  almost-full level; 0 disables `almost_full`.
- `empty_threshold`  in  PTR  almost-empty level.
- `fifo_data_out`  out  WORD_SIZE  registered read data.
- `fifo_valid`  out  1  `fifo_data_out` holds a word popped the previous cycle.
- `fifo_empty`  out  1  count == 0.
- `fifo_full`  out  1  count == MEM_SIZE.
- `almost_full`  out  1  full_threshold != 0 and count >= full_threshold.
- `almost_empty`  out  1  count <= empty_threshold.
- `fifo_error`  out  1  sticky overflow/underflow flag.
- `count`  out  PTR+1  number of stored words, 0..MEM_SIZE.

## Operation
- **Storage:** MEM_SIZE x WORD_SIZE array, plus write pointer `wr_ptr`, read pointer `rd_ptr` (PTR bits each) and `count` (PTR+1 bits).
- **Pointer wrap:** both pointers increment modulo MEM_SIZE (natural PTR-bit wrap, 7 -> 0).
- **Write accepted** when `fifo_wr` and (not full, or `fifo_rd` accepted in the same cycle):
  - mem[wr_ptr] <= `fifo_data_in`; `wr_ptr` + 1.
- **Read accepted** when `fifo_rd` and count != 0:
  - `fifo_data_out` <= mem[rd_ptr]; `rd_ptr` + 1.
  - `fifo_valid` <= 1 for the next cycle; otherwise `fifo_valid` <= 0.
  - `fifo_data_out` holds its last value when no read occurs.
- **Count update:**
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- **Full with rd and wr together:** both accepted; count stays MEM_SIZE; no error.
- **Empty with rd and wr together:** write accepted; read ignored (no bypass); `fifo_error` set; count becomes 1.
- **Overflow:** write when full without a simultaneous read is dropped; memory and pointers unchanged; `fifo_error` <= 1.
- **Underflow:** read when empty is ignored; `fifo_valid` <= 0; `fifo_error` <= 1.
- **`fifo_error`:** cleared only by reset.
- **Status flags:** `fifo_empty`, `fifo_full`, `almost_full`, `almost_empty` are combinational from the `count` register and the live threshold inputs. They are glitch-free relative to `clk` because all operands are registered.
- **Threshold changes** take effect on the flags in the same cycle the threshold input changes. No FIFO contents or pointers are affected.
- **Flag examples:** with `empty_threshold` = 0, `almost_empty` equals `fifo_empty`. With `full_threshold` = 7, `almost_full` asserts at count >= 7.

## Timing
- **Reset** (`reset` = 0 at a rising edge), applied to these values:
  - `wr_ptr` = `rd_ptr` = 0.
  - `count` = 0.
  - `fifo_data_out` = 0.
  - `fifo_valid` = 0.
  - `fifo_error` = 0.
- **Flag values after reset:** `fifo_empty` = 1, `fifo_full` = 0, `almost_full` = 0, `almost_empty` = 1.
- **Reset memory:** array contents are not reset. They are unobservable because count = 0.
- **Reset mid-operation:** reset overrides `fifo_wr`/`fifo_rd` in that cycle; all queued words are discarded.
- **Write latency:** a write accepted at edge N is counted at N; `fifo_empty` falls after edge N. The word is readable by a read request presented in cycle N+1.
- **Read latency:** a read sampled at edge N gives `fifo_data_out`/`fifo_valid` valid after edge N, for one cycle.
- **Throughput:** one write and one read per cycle, sustained.
- **Empty-bus update:** `fifo_empty` reaches the state machine's `fifos_empty` bus with zero added latency. An IDLE->ACTIVE transition happens at the edge following the first accepted write.

## Test plan
- **Reset / write / read:** reset, then write 0xA5B, then read -> `fifo_empty` 1 -> 0 -> 1; `fifo_data_out` = 0xA5B with `fifo_valid` = 1 exactly one cycle after `fifo_rd`; `count` 0 -> 1 -> 0.
- **Fill and overflow:** write 8 words 0x001..0x008, then a 9th write 0xFFF -> `fifo_full` = 1, `count` = 8, `fifo_error` = 1. Draining 8 reads returns 0x001..0x008 in order; 0xFFF never appears.
- **Thresholds:** `full_threshold` = 6, `empty_threshold` = 2; fill one word per cycle -> `almost_empty` high for count 0..2 and low at 3. `almost_full` rises when count reaches 6.
- **Full with rd and wr together:** at count = 8, assert `fifo_rd` and `fifo_wr` (0x3C0) together -> count stays 8, no error. 0x3C0 is read out ninth after the original 8 words.
- **Underflow:** on an empty FIFO, assert `fifo_rd` with `fifo_wr` (0x155) -> `fifo_valid` = 0, `fifo_error` = 1, count = 1. The next read returns 0x155.
- **Wrap and reset mid-stream:** 20 cycles of continuous simultaneous rd/wr at count = 4 -> data order preserved across pointer wrap. Then assert reset with count = 4 -> next cycle count = 0, `fifo_error` = 0, `fifo_valid` = 0.
